// File: rtl/execute_unit_pkg.sv
// Shared widths, decoded instruction ids and the ALU result payload for the integer execute stage.
package execute_unit_pkg;

    localparam int unsigned WordWidth    = 32;
    localparam int unsigned AddrWidth    = 32;
    localparam int unsigned ImmWidth     = 32;
    localparam int unsigned InstrIdWidth = 6;
    localparam int unsigned ROBIdxWidth  = 4;

    // Id 0 means "no instruction"; load/store ids exist but never produce results here.
    typedef enum logic [InstrIdWidth-1:0] {
        ID_NONE  = 6'd0,
        ID_LUI   = 6'd1,
        ID_AUIPC = 6'd2,
        ID_JAL   = 6'd3,
        ID_JALR  = 6'd4,
        ID_BEQ   = 6'd5,
        ID_BNE   = 6'd6,
        ID_BLT   = 6'd7,
        ID_BGE   = 6'd8,
        ID_BLTU  = 6'd9,
        ID_BGEU  = 6'd10,
        ID_LB    = 6'd11,
        ID_LH    = 6'd12,
        ID_LW    = 6'd13,
        ID_LBU   = 6'd14,
        ID_LHU   = 6'd15,
        ID_SB    = 6'd16,
        ID_SH    = 6'd17,
        ID_SW    = 6'd18,
        ID_ADDI  = 6'd19,
        ID_SLTI  = 6'd20,
        ID_SLTIU = 6'd21,
        ID_XORI  = 6'd22,
        ID_ORI   = 6'd23,
        ID_ANDI  = 6'd24,
        ID_SLLI  = 6'd25,
        ID_SRLI  = 6'd26,
        ID_SRAI  = 6'd27,
        ID_ADD   = 6'd28,
        ID_SUB   = 6'd29,
        ID_SLL   = 6'd30,
        ID_SLT   = 6'd31,
        ID_SLTU  = 6'd32,
        ID_XOR   = 6'd33,
        ID_SRL   = 6'd34,
        ID_SRA   = 6'd35,
        ID_OR    = 6'd36,
        ID_AND   = 6'd37
    } instr_id_e;

    typedef struct packed {
        logic [WordWidth-1:0] res;
        logic                 jump;
        logic [AddrWidth-1:0] target;
    } alu_out_t;

endpackage

// File: rtl/execute_unit_if.sv
// Dispatch (reservation station -> execute) and result broadcast (execute -> RS/LSB/ROB) bundle.
interface execute_unit_if;
    import execute_unit_pkg::*;

    logic                    rs_to_ex_en_in;
    logic [InstrIdWidth-1:0] instr_id_in;
    logic [ImmWidth-1:0]     imm_in;
    logic [WordWidth-1:0]    rs1_in;
    logic [WordWidth-1:0]    rs2_in;
    logic [AddrWidth-1:0]    pc_in;
    logic [ROBIdxWidth-1:0]  rob_pos_in;

    logic                    ex_to_rs_en_out;
    logic [ROBIdxWidth-1:0]  ex_to_rs_rob_pos_out;
    logic [WordWidth-1:0]    ex_to_rs_res_out;
    logic                    ex_jump_out;
    logic [AddrWidth-1:0]    ex_target_out;

    modport master (
        output rs_to_ex_en_in, instr_id_in, imm_in, rs1_in, rs2_in, pc_in, rob_pos_in,
        input  ex_to_rs_en_out, ex_to_rs_rob_pos_out, ex_to_rs_res_out, ex_jump_out, ex_target_out
    );

    modport slave (
        input  rs_to_ex_en_in, instr_id_in, imm_in, rs1_in, rs2_in, pc_in, rob_pos_in,
        output ex_to_rs_en_out, ex_to_rs_rob_pos_out, ex_to_rs_res_out, ex_jump_out, ex_target_out
    );

endinterface

// File: rtl/execute_unit_alu_core.sv
// Combinational RV32I integer datapath: rd value, control-transfer decision and redirect target.
module alu_core
    import execute_unit_pkg::*;
(
    input  logic [InstrIdWidth-1:0] instr_id,
    input  logic [ImmWidth-1:0]     imm,
    input  logic [WordWidth-1:0]    rs1,
    input  logic [WordWidth-1:0]    rs2,
    input  logic [AddrWidth-1:0]    pc,
    output alu_out_t                out_c
);

    logic [AddrWidth-1:0] seq_pc;
    logic [AddrWidth-1:0] br_target;
    logic [4:0]           shamt_i;
    logic [4:0]           shamt_r;

    assign seq_pc    = pc + AddrWidth'(4);
    assign br_target = pc + imm;
    assign shamt_i   = imm[4:0];
    assign shamt_r   = rs2[4:0];

    // Non-control ops and unknown ids fall through with jump = 0 and target = pc + 4.
    always_comb begin
        out_c.res    = '0;
        out_c.jump   = 1'b0;
        out_c.target = seq_pc;
        case (instr_id)
            ID_LUI:   out_c.res = imm;
            ID_AUIPC: out_c.res = pc + imm;
            ID_JAL: begin
                out_c.res    = seq_pc;
                out_c.jump   = 1'b1;
                out_c.target = br_target;
            end
            ID_JALR: begin
                out_c.res    = seq_pc;
                out_c.jump   = 1'b1;
                out_c.target = (rs1 + imm) & ~AddrWidth'(1);
            end
            ID_BEQ:  begin out_c.jump = (rs1 == rs2);                   out_c.target = br_target; end
            ID_BNE:  begin out_c.jump = (rs1 != rs2);                   out_c.target = br_target; end
            ID_BLT:  begin out_c.jump = ($signed(rs1) <  $signed(rs2)); out_c.target = br_target; end
            ID_BGE:  begin out_c.jump = ($signed(rs1) >= $signed(rs2)); out_c.target = br_target; end
            ID_BLTU: begin out_c.jump = (rs1 <  rs2);                   out_c.target = br_target; end
            ID_BGEU: begin out_c.jump = (rs1 >= rs2);                   out_c.target = br_target; end
            ID_ADDI:  out_c.res = rs1 + imm;
            ID_SLTI:  out_c.res = WordWidth'($signed(rs1) < $signed(imm));
            ID_SLTIU: out_c.res = WordWidth'(rs1 < imm);
            ID_XORI:  out_c.res = rs1 ^ imm;
            ID_ORI:   out_c.res = rs1 | imm;
            ID_ANDI:  out_c.res = rs1 & imm;
            ID_SLLI:  out_c.res = rs1 << shamt_i;
            ID_SRLI:  out_c.res = rs1 >> shamt_i;
            ID_SRAI:  out_c.res = $unsigned($signed(rs1) >>> shamt_i);
            ID_ADD:   out_c.res = rs1 + rs2;
            ID_SUB:   out_c.res = rs1 - rs2;
            ID_SLL:   out_c.res = rs1 << shamt_r;
            ID_SLT:   out_c.res = WordWidth'($signed(rs1) < $signed(rs2));
            ID_SLTU:  out_c.res = WordWidth'(rs1 < rs2);
            ID_XOR:   out_c.res = rs1 ^ rs2;
            ID_SRL:   out_c.res = rs1 >> shamt_r;
            ID_SRA:   out_c.res = $unsigned($signed(rs1) >>> shamt_r);
            ID_OR:    out_c.res = rs1 | rs2;
            ID_AND:   out_c.res = rs1 & rs2;
            default: ;
        endcase
    end

endmodule

// File: rtl/execute_unit.sv
// Single-cycle integer execute stage: ALU plus one output register stage feeding the result broadcast.
module execute_unit
    import execute_unit_pkg::*;
(
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           rdy_in,
    input  logic           clear_branch_in,
    execute_unit_if.slave  bus
);

    alu_out_t alu_out_c;

    logic                   en_q,     en_d;
    logic                   jump_q,   jump_d;
    logic [ROBIdxWidth-1:0] pos_q,    pos_d;
    logic [WordWidth-1:0]   res_q,    res_d;
    logic [AddrWidth-1:0]   target_q, target_d;

    alu_core u_alu_core (
        .instr_id (bus.instr_id_in),
        .imm      (bus.imm_in),
        .rs1      (bus.rs1_in),
        .rs2      (bus.rs2_in),
        .pc       (bus.pc_in),
        .out_c    (alu_out_c)
    );

    // Priority: stall > flush > dispatch; data fields hold when nothing is captured.
    always_comb begin
        en_d     = en_q;
        jump_d   = jump_q;
        pos_d    = pos_q;
        res_d    = res_q;
        target_d = target_q;
        if (rdy_in) begin
            en_d   = 1'b0;
            jump_d = 1'b0;
            if (!clear_branch_in && bus.rs_to_ex_en_in) begin
                en_d     = 1'b1;
                jump_d   = alu_out_c.jump;
                pos_d    = bus.rob_pos_in;
                res_d    = alu_out_c.res;
                target_d = alu_out_c.target;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            en_q     <= 1'b0;
            jump_q   <= 1'b0;
            pos_q    <= '0;
            res_q    <= '0;
            target_q <= '0;
        end else begin
            en_q     <= en_d;
            jump_q   <= jump_d;
            pos_q    <= pos_d;
            res_q    <= res_d;
            target_q <= target_d;
        end
    end

    assign bus.ex_to_rs_en_out      = en_q;
    assign bus.ex_jump_out          = jump_q;
    assign bus.ex_to_rs_rob_pos_out = pos_q;
    assign bus.ex_to_rs_res_out     = res_q;
    assign bus.ex_target_out        = target_q;

endmodule

// File: tb/tb_execute_unit.sv
// Directed self-checking bench for execute_unit with hand-computed expectations.
module tb_execute_unit;
    import execute_unit_pkg::*;

    logic clk_in;
    logic rst_in;
    logic rdy_in;
    logic clear_branch_in;
    int   checks;
    int   errors;

    execute_unit_if bus ();

    execute_unit dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .clear_branch_in (clear_branch_in),
        .bus             (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input instr_id_e id, input logic [31:0] imm, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] pc, input logic [3:0] pos);
        bus.rs_to_ex_en_in = 1'b1;
        bus.instr_id_in    = id;
        bus.imm_in         = imm;
        bus.rs1_in         = rs1;
        bus.rs2_in         = rs2;
        bus.pc_in          = pc;
        bus.rob_pos_in     = pos;
    endtask

    task automatic idle();
        bus.rs_to_ex_en_in = 1'b0;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic en, input logic [3:0] pos,
                           input logic [31:0] res, input logic jump, input logic [31:0] tgt);
        chk({tag, ".en"},     32'(bus.ex_to_rs_en_out), 32'(en));
        chk({tag, ".pos"},    32'(bus.ex_to_rs_rob_pos_out), 32'(pos));
        chk({tag, ".res"},    bus.ex_to_rs_res_out, res);
        chk({tag, ".jump"},   32'(bus.ex_jump_out), 32'(jump));
        chk({tag, ".target"}, bus.ex_target_out, tgt);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_in = 1'b1;
        rdy_in = 1'b1;
        clear_branch_in = 1'b0;
        bus.rs_to_ex_en_in = 1'b0;
        bus.instr_id_in = ID_NONE;
        bus.imm_in = '0;
        bus.rs1_in = '0;
        bus.rs2_in = '0;
        bus.pc_in = '0;
        bus.rob_pos_in = '0;

        // Reset values, with a dispatch present that reset must ignore
        drive(ID_ADD, 32'd0, 32'd5, 32'd6, 32'h10, 4'd7);
        step();
        chk_all("reset", 1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
        idle();
        rst_in = 1'b0;
        step();

        // ADD overflow wraps; valid for exactly one cycle
        drive(ID_ADD, 32'd0, 32'h7FFF_FFFF, 32'd1, 32'h40, 4'd3);
        step();
        chk_all("add", 1'b1, 4'd3, 32'h8000_0000, 1'b0, 32'h44);
        idle();
        step();
        chk("add_drop.en", 32'(bus.ex_to_rs_en_out), 32'd0);
        chk("add_hold.res", bus.ex_to_rs_res_out, 32'h8000_0000);

        // Shifts, back to back
        drive(ID_SRAI, 32'd4, 32'h8000_0010, 32'd0, 32'h50, 4'd4);
        step();
        chk("srai.res", bus.ex_to_rs_res_out, 32'hF800_0001);
        drive(ID_SRLI, 32'd4, 32'h8000_0010, 32'd0, 32'h54, 4'd5);
        step();
        chk("srli.res", bus.ex_to_rs_res_out, 32'h0800_0001);
        chk("srli.en", 32'(bus.ex_to_rs_en_out), 32'd1);

        // Signed vs unsigned branch compare
        drive(ID_BLT, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'd1, 32'h100, 4'd6);
        step();
        chk_all("blt", 1'b1, 4'd6, 32'h0, 1'b1, 32'hF8);
        drive(ID_BLTU, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'd1, 32'h100, 4'd7);
        step();
        chk("bltu.jump", 32'(bus.ex_jump_out), 32'd0);
        chk("bltu.res", bus.ex_to_rs_res_out, 32'h0);

        // JALR clears bit 0 of the target
        drive(ID_JALR, 32'd4, 32'h1003, 32'd0, 32'h200, 4'd8);
        step();
        chk_all("jalr", 1'b1, 4'd8, 32'h204, 1'b1, 32'h1006);
        drive(ID_JAL, 32'h40, 32'd0, 32'd0, 32'h300, 4'd9);
        step();
        chk_all("jal", 1'b1, 4'd9, 32'h304, 1'b1, 32'h340);

        // Misc ALU ops
        drive(ID_LUI, 32'h1234_5000, 32'd9, 32'd9, 32'h500, 4'd10);
        step();
        chk_all("lui", 1'b1, 4'd10, 32'h1234_5000, 1'b0, 32'h504);
        drive(ID_AUIPC, 32'h2000, 32'd0, 32'd0, 32'h1000, 4'd11);
        step();
        chk("auipc.res", bus.ex_to_rs_res_out, 32'h3000);
        drive(ID_SUB, 32'd0, 32'd5, 32'd7, 32'h600, 4'd12);
        step();
        chk("sub.res", bus.ex_to_rs_res_out, 32'hFFFF_FFFE);
        drive(ID_SLTIU, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h604, 4'd13);
        step();
        chk("sltiu.res", bus.ex_to_rs_res_out, 32'd1);
        drive(ID_SLTI, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h608, 4'd14);
        step();
        chk("slti.res", bus.ex_to_rs_res_out, 32'd0);
        drive(ID_BGEU, 32'h20, 32'hFFFF_FFFF, 32'd1, 32'h700, 4'd15);
        step();
        chk_all("bgeu", 1'b1, 4'd15, 32'h0, 1'b1, 32'h720);

        // Load id is still broadcast with a zero result
        drive(ID_LW, 32'h10, 32'd3, 32'd4, 32'h400, 4'd2);
        step();
        chk_all("unlisted", 1'b1, 4'd2, 32'h0, 1'b0, 32'h404);
        idle();
        step();

        // Three back-to-back dispatches
        for (int i = 1; i <= 3; i++) begin
            drive(ID_ADDI, 32'(i), 32'h100, 32'd0, 32'h800, 4'(i));
            step();
            chk($sformatf("b2b%0d.pos", i), 32'(bus.ex_to_rs_rob_pos_out), 32'(i));
            chk($sformatf("b2b%0d.res", i), bus.ex_to_rs_res_out, 32'h100 + 32'(i));
            chk($sformatf("b2b%0d.en", i), 32'(bus.ex_to_rs_en_out), 32'd1);
        end
        idle();
        step();

        // Flush with the third dispatch drops it
        drive(ID_ADDI, 32'd1, 32'd0, 32'd0, 32'h900, 4'd1);
        step();
        chk("flush1.pos", 32'(bus.ex_to_rs_rob_pos_out), 32'd1);
        drive(ID_JAL, 32'h80, 32'd0, 32'd0, 32'h904, 4'd2);
        step();
        chk("flush2.pos", 32'(bus.ex_to_rs_rob_pos_out), 32'd2);
        chk("flush2.jump", 32'(bus.ex_jump_out), 32'd1);
        drive(ID_ADDI, 32'd3, 32'd0, 32'd0, 32'h908, 4'd3);
        clear_branch_in = 1'b1;
        step();
        chk("flush3.en", 32'(bus.ex_to_rs_en_out), 32'd0);
        chk("flush3.jump", 32'(bus.ex_jump_out), 32'd0);
        clear_branch_in = 1'b0;
        idle();
        step();

        // Async reset mid-broadcast
        drive(ID_ADD, 32'd0, 32'd2, 32'd3, 32'hA00, 4'd5);
        step();
        chk("pre_rst.en", 32'(bus.ex_to_rs_en_out), 32'd1);
        idle();
        #2 rst_in = 1'b1;
        #1;
        chk_all("async_rst", 1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
        #2 rst_in = 1'b0;
        step();

        // Stall holds a pending broadcast
        drive(ID_JAL, 32'h10, 32'd0, 32'd0, 32'hB00, 4'd6);
        step();
        chk_all("pre_stall", 1'b1, 4'd6, 32'hB04, 1'b1, 32'hB10);
        rdy_in = 1'b0;
        drive(ID_ADD, 32'd0, 32'd1, 32'd1, 32'hC00, 4'd9);
        step();
        chk_all("stall1", 1'b1, 4'd6, 32'hB04, 1'b1, 32'hB10);
        step();
        chk_all("stall2", 1'b1, 4'd6, 32'hB04, 1'b1, 32'hB10);
        rdy_in = 1'b1;
        idle();
        step();
        chk("post_stall.en", 32'(bus.ex_to_rs_en_out), 32'd0);
        chk("post_stall.pos", 32'(bus.ex_to_rs_rob_pos_out), 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
